// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 DIT forward/inverse DFT: collects a 4-sample frame,
// runs two registered butterfly stages, then drains the bins with backpressure.
module fft4_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode_inv,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH+1:0] out_real,
  output logic signed [DATA_WIDTH+1:0] out_imag,
  output logic [1:0]                   out_index,
  output logic                         out_last,
  output logic                         frame_err,
  output logic [CNT_WIDTH-1:0]         frames_done
);
  localparam int AW = DATA_WIDTH + 1;
  localparam int OW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {ST_COLLECT, ST_S1, ST_S2, ST_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, k_q;
  logic                 mode_q;
  logic                 frame_err_q;
  logic [CNT_WIDTH-1:0] frames_q;

  logic signed [DATA_WIDTH-1:0] xr_q [4];
  logic signed [DATA_WIDTH-1:0] xi_q [4];
  logic signed [AW-1:0] ar_q, ai_q, br_q, bi_q, cr_q, ci_q, dr_q, di_q;
  logic signed [OW-1:0] bank_re_q [4];
  logic signed [OW-1:0] bank_im_q [4];
  logic signed [OW-1:0] bin_re [4];
  logic signed [OW-1:0] bin_im [4];
  logic signed [OW-1:0] out_re_q, out_im_q;

  logic accept, bad_frame, hs;

  function automatic logic signed [AW-1:0] ext1(input logic signed [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-1], v};
  endfunction

  function automatic logic signed [OW-1:0] ext2(input logic signed [AW-1:0] v);
    return {v[AW-1], v};
  endfunction

  assign accept    = in_valid && in_ready;
  // in_last must coincide exactly with the 4th sample, otherwise the frame is dropped
  assign bad_frame = accept && (in_last != (idx_q == 2'd3));
  assign hs        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (accept && !bad_frame && idx_q == 2'd3) state_d = ST_S1;
      ST_S1:      state_d = ST_S2;
      ST_S2:      state_d = ST_DRAIN;
      ST_DRAIN:   if (hs && k_q == 2'd3) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    out_valid = (state_q == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= 2'd0;
      mode_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (accept) begin
      if (idx_q == 2'd0) mode_q <= mode_inv;
      if (bad_frame) begin
        idx_q       <= 2'd0;
        frame_err_q <= 1'b1;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sample
      always_ff @(posedge clk) begin
        if (rst) begin
          xr_q[gi] <= '0;
          xi_q[gi] <= '0;
        end else if (accept && idx_q == 2'(gi)) begin
          xr_q[gi] <= in_real;
          xi_q[gi] <= in_imag;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      {ar_q, ai_q, br_q, bi_q, cr_q, ci_q, dr_q, di_q} <= '0;
    end else if (state_q == ST_S1) begin
      ar_q <= ext1(xr_q[0]) + ext1(xr_q[2]);
      ai_q <= ext1(xi_q[0]) + ext1(xi_q[2]);
      br_q <= ext1(xr_q[0]) - ext1(xr_q[2]);
      bi_q <= ext1(xi_q[0]) - ext1(xi_q[2]);
      cr_q <= ext1(xr_q[1]) + ext1(xr_q[3]);
      ci_q <= ext1(xi_q[1]) + ext1(xi_q[3]);
      dr_q <= ext1(xr_q[1]) - ext1(xr_q[3]);
      di_q <= ext1(xi_q[1]) - ext1(xi_q[3]);
    end
  end

  // Inverse differs from forward only by exchanging the odd bins
  always_comb begin
    bin_re[0] = ext2(ar_q) + ext2(cr_q);
    bin_im[0] = ext2(ai_q) + ext2(ci_q);
    bin_re[2] = ext2(ar_q) - ext2(cr_q);
    bin_im[2] = ext2(ai_q) - ext2(ci_q);
    bin_re[1] = ext2(br_q) + ext2(di_q);
    bin_im[1] = ext2(bi_q) - ext2(dr_q);
    bin_re[3] = ext2(br_q) - ext2(di_q);
    bin_im[3] = ext2(bi_q) + ext2(dr_q);
    if (mode_q) begin
      bin_re[1] = ext2(br_q) - ext2(di_q);
      bin_im[1] = ext2(bi_q) + ext2(dr_q);
      bin_re[3] = ext2(br_q) + ext2(di_q);
      bin_im[3] = ext2(bi_q) - ext2(dr_q);
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      always_ff @(posedge clk) begin
        if (rst) begin
          bank_re_q[gi] <= '0;
          bank_im_q[gi] <= '0;
        end else if (state_q == ST_S2) begin
          bank_re_q[gi] <= bin_re[gi];
          bank_im_q[gi] <= bin_im[gi];
        end
      end
    end
  endgenerate

  // Output registers keep the last bin after the drain finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      out_re_q <= '0;
      out_im_q <= '0;
      k_q      <= 2'd0;
      frames_q <= '0;
    end else if (state_q == ST_S2) begin
      out_re_q <= bin_re[0];
      out_im_q <= bin_im[0];
      k_q      <= 2'd0;
    end else if (hs) begin
      if (k_q == 2'd3) begin
        frames_q <= frames_q + 1'b1;
      end else begin
        out_re_q <= bank_re_q[k_q + 2'd1];
        out_im_q <= bank_im_q[k_q + 2'd1];
        k_q      <= k_q + 2'd1;
      end
    end
  end

  assign out_real    = out_re_q;
  assign out_imag    = out_im_q;
  assign out_index   = k_q;
  assign out_last    = (k_q == 2'd3);
  assign frame_err   = frame_err_q;
  assign frames_done = frames_q;
endmodule

// File: tb/tb_fft4_stream.sv
// Randomized and directed frames for fft4_stream, checked against a direct
// DFT sum over powers of -j (forward) or +j (inverse).
module tb_fft4_stream;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst, mode_inv, in_valid, in_ready, in_last;
  logic signed [DW-1:0] in_real, in_imag;
  logic out_valid, out_ready, out_last, frame_err;
  logic signed [DW+1:0] out_real, out_imag;
  logic [1:0] out_index;
  logic [CW-1:0] frames_done;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  int xr [4];
  int xi [4];
  int er [4];
  int ei [4];

  fft4_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mode_inv(mode_inv),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_last(out_last), .frame_err(frame_err), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // X[k] = sum_n x[n] * w^(n*k), w = -j forward, +j inverse
  task automatic model(input bit inv);
    for (int k = 0; k < 4; k++) begin
      int ar, ai, p;
      ar = 0; ai = 0;
      for (int n = 0; n < 4; n++) begin
        p = (n * k) % 4;
        if (inv) p = (4 - p) % 4;
        case (p)
          0: begin ar += xr[n]; ai += xi[n]; end
          1: begin ar += xi[n]; ai -= xr[n]; end
          2: begin ar -= xr[n]; ai -= xi[n]; end
          default: begin ar -= xi[n]; ai += xr[n]; end
        endcase
      end
      er[k] = ar; ei[k] = ai;
    end
  endtask

  function automatic bit ready_at(input int style, input int cyc);
    case (style)
      0: return 1'b1;
      1: return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Sends xr/xi as one frame, then drains up to stop_k bins.
  task automatic run_frame(input bit inv, input int style, input bit gaps, input int stop_k);
    int lat, k, cyc;
    bit rdy;
    model(inv);
    for (int n = 0; n < 4; n++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        step();
      end
      chk("in_ready_collect", int'(in_ready), 1);
      in_valid = 1'b1;
      in_real  = DW'(xr[n]);
      in_imag  = DW'(xi[n]);
      in_last  = (n == 3);
      mode_inv = (n == 0) ? inv : 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      chk("in_ready_busy", int'(in_ready), 0);
      step();
      lat++;
    end
    chk("latency", lat, 2);
    k = 0;
    cyc = 0;
    while (k < stop_k && cyc < 200) begin
      rdy = ready_at(style, cyc);
      out_ready = rdy;
      #1;
      $display("bin k=%0d valid=%0d rdy=%0d re=%0d im=%0d exp=(%0d,%0d)",
               k, out_valid, rdy, $signed(out_real), $signed(out_imag), er[k], ei[k]);
      chk("out_valid", int'(out_valid), 1);
      chk("out_index", int'(out_index), k);
      chk("out_real", int'($signed(out_real)), er[k]);
      chk("out_imag", int'($signed(out_imag)), ei[k]);
      chk("out_last", int'(out_last), int'(k == 3));
      chk("in_ready_drain", int'(in_ready), 0);
      step();
      if (rdy) k++;
      cyc++;
    end
    chk("drain_done", k, stop_k);
    out_ready = 1'b0;
    if (stop_k == 4) begin
      exp_frames++;
      chk("post_valid", int'(out_valid), 0);
      chk("post_in_ready", int'(in_ready), 1);
      chk("frames_done", int'(frames_done), exp_frames);
      chk("hold_real", int'($signed(out_real)), er[3]);
    end
  endtask

  task automatic set_frame(input int r0, i0, r1, i1, r2, i2, r3, i3);
    xr[0] = r0; xi[0] = i0; xr[1] = r1; xi[1] = i1;
    xr[2] = r2; xi[2] = i2; xr[3] = r3; xi[3] = i3;
  endtask

  task automatic rand_frame();
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($signed(DW'($urandom)));
      xi[n] = int'($signed(DW'($urandom)));
    end
  endtask

  initial begin
    rst = 1'b1; mode_inv = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_real = '0; in_imag = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_real", int'(out_real), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_frames", int'(frames_done), 0);

    set_frame(1, 0, 2, 0, 3, 0, 4, 0);
    run_frame(1'b0, 0, 1'b0, 4);
    chk("fwd_basic_x1re", er[1], -2);
    run_frame(1'b1, 0, 1'b0, 4);
    set_frame(-128, -128, -128, -128, -128, -128, -128, -128);
    run_frame(1'b0, 0, 1'b0, 4);
    set_frame(127, 0, 0, 127, -128, 0, 0, -128);
    run_frame(1'b0, 1, 1'b0, 4);
    run_frame(1'b1, 1, 1'b0, 4);

    // Framing error: in_last on the 2nd sample
    in_valid = 1'b1; in_real = 8'sd5; in_imag = 8'sd6; in_last = 1'b0; step();
    in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("ferr_set", int'(frame_err), 1);
    chk("ferr_no_out", int'(out_valid), 0);
    chk("ferr_in_ready", int'(in_ready), 1);
    step(); step();
    chk("ferr_no_out2", int'(out_valid), 0);
    rand_frame();
    run_frame(1'b0, 2, 1'b1, 4);
    chk("ferr_sticky", int'(frame_err), 1);

    for (int f = 0; f < 24; f++) begin
      rand_frame();
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 4);
    end

    // Reset after two bins drained
    rand_frame();
    run_frame(1'b0, 0, 1'b0, 2);
    rst = 1'b1; step(); rst = 1'b0;
    exp_frames = 0;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    chk("mrst_frames", int'(frames_done), 0);
    chk("mrst_frame_err", int'(frame_err), 0);
    rand_frame();
    run_frame(1'b1, 2, 1'b0, 4);
    rand_frame();
    run_frame(1'b0, 0, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end
endmodule
